// File: rtl/pmcc_pkg.sv
// Shared types and default sizing for the PMC coprocessor wait engine.
package pmcc_pkg;

  localparam int PMCC_TRIG_NUM    = 4;
  localparam int PMCC_TIMEOUT_W   = 16;
  localparam int PMCC_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_t;

  // Wait command captured at start. While waiting, the timeout field is the
  // live down-counter of remaining WAIT cycles (0 = no timeout).
  typedef struct packed {
    logic [PMCC_TRIG_NUM-1:0]  mask;
    logic                      all_mode;
    logic                      edge_mode;
    logic [PMCC_TIMEOUT_W-1:0] timeout;
  } wait_cmd_t;

endpackage

// File: rtl/pmcc_trigger_sync.sv
// Multi-flop synchroniser for the asynchronous trigger pins plus one delayed
// copy for rising-edge detection. The delay flop runs in every state, so a
// rise that settles before a wait starts is not seen as an edge.
module pmcc_trigger_sync
  import pmcc_pkg::*;
#(
  parameter int WIDTH  = PMCC_TRIG_NUM,
  parameter int STAGES = PMCC_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] trig_async,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             level_d;

  // Shift the raw triggers through the synchroniser chain and keep last level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_d <= '0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], trig_async};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~level_d;

endmodule

// File: rtl/pmcc_wait_unit.sv
// Multi-channel wait engine: stalls the coprocessor until a programmed
// combination of triggers, a timeout, or an abort ends the wait.
//
//  state | meaning
//  IDLE  | no wait active; waitt latches a command and starts a wait
//  WAIT  | stalling; leaves on condition met, timeout or abort
module pmcc_wait_unit
  import pmcc_pkg::*;
#(
  parameter int TRIG_NUM    = PMCC_TRIG_NUM,
  parameter int TIMEOUT_W   = PMCC_TIMEOUT_W,
  parameter int SYNC_STAGES = PMCC_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 waitt,
  input  logic [TRIG_NUM-1:0]  trig_mask,
  input  logic                 all_mode,
  input  logic                 edge_mode,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 abort,
  input  logic [TRIG_NUM-1:0]  trigger,
  output logic                 waiting,
  output logic                 done,
  output logic                 timed_out,
  output logic [TRIG_NUM-1:0]  trig_hit
);

  wait_state_t         state, state_nxt;
  wait_cmd_t           cmd_in, cmd_q;
  logic [TRIG_NUM-1:0] trig_level, trig_rise, ev, hit_nxt;
  logic                cond_met, tmo_hit, wait_rel;

  pmcc_trigger_sync #(
    .WIDTH  (TRIG_NUM),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_async (trigger),
    .level      (trig_level),
    .rise       (trig_rise)
  );

  // Pack the start-of-wait command from the decode inputs.
  always_comb begin
    cmd_in           = '0;
    cmd_in.mask      = trig_mask;
    cmd_in.all_mode  = all_mode;
    cmd_in.edge_mode = edge_mode;
    cmd_in.timeout   = timeout;
  end

  // Trigger evaluation; an empty mask is satisfied immediately in both modes.
  always_comb begin
    ev       = cmd_q.edge_mode ? trig_rise : trig_level;
    hit_nxt  = trig_hit | (ev & cmd_q.mask);
    cond_met = (cmd_q.mask == '0) |
               (cmd_q.all_mode ? &(hit_nxt | ~cmd_q.mask) : |hit_nxt);
    tmo_hit  = (cmd_q.timeout == PMCC_TIMEOUT_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the combinational stall request.
  always_comb begin
    state_nxt = state;
    waiting   = 1'b0;
    wait_rel  = 1'b0;
    case (state)
      IDLE: begin
        waiting = waitt;
        if (waitt) state_nxt = WAIT;
      end
      WAIT: begin
        wait_rel = abort | cond_met | tmo_hit;
        waiting  = ~wait_rel;
        if (wait_rel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, timeout down-counter, sticky hits and end-of-wait status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      trig_hit  <= '0;
      timed_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (waitt) begin
            cmd_q     <= cmd_in;
            trig_hit  <= '0;
            timed_out <= 1'b0;
          end
        end
        WAIT: begin
          trig_hit <= hit_nxt;
          if (cmd_q.timeout != '0)
            cmd_q.timeout <= cmd_q.timeout - PMCC_TIMEOUT_W'(1);
          if (wait_rel) begin
            done      <= ~abort;
            timed_out <= tmo_hit & ~cond_met & ~abort;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
